hwgq_seq: RTL and testbench
===========================

HWGQ_SEQ -- requirements
Module: hwgq_seq

Interface
REQ-001 Parameter SKEW_DEPTH, default 32: length of the datapath's staggered per-lane reset chain.
REQ-002 Parameter RUN_W, default 6: width of the run-length configuration field.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 start  input  1  pass request; accepted only when start && ready at a rising edge.
REQ-006 run_len  input  RUN_W  quantization window length in cycles; sampled only on the accepting edge.
REQ-007 abort  input  1  truncates the pass in progress.
REQ-008 ready  output  1  high exactly when state = IDLE.
REQ-009 busy  output  1  high in RUN, FLUSH and DONE.
REQ-010 requant_en  output  1  registered; drives the datapath reset-chain shift enable.
REQ-011 start_quantizing  output  1  registered; drives the datapath chain head.
REQ-012 grp_valid  output  1  registered; the lane group in grp_idx has just re-entered reset and its result is stable.
REQ-013 grp_idx  output  5  registered; chain tap index 0..SKEW_DEPTH-1 qualified by grp_valid.
REQ-014 done  output  1  registered one-cycle pulse marking pass completion.
REQ-015 aborted  output  1  registered; valid only while done = 1; high if the pass was truncated.

Function
REQ-016 The state machine SHALL have the states IDLE, RUN, FLUSH and DONE, plus a counter cnt of width max(RUN_W, 6).
REQ-017 IDLE: requant_en = 0 and start_quantizing = 0; on start && !abort the block SHALL latch len = (run_len == 0 ? 1 : run_len), clear cnt and the abort flag, and move to RUN.
REQ-018 IDLE with start && abort on the same edge: the start SHALL be ignored and the state SHALL stay IDLE.
REQ-019 RUN: requant_en = 1 and start_quantizing = 1, for exactly len cycles; after the len-th cycle the block SHALL clear cnt and move to FLUSH.
REQ-020 RUN with abort = 1: the block SHALL set the abort flag, clear cnt and move to FLUSH on that edge; that cycle still counts as a RUN cycle.
REQ-021 FLUSH: requant_en = 1 and start_quantizing = 0, for exactly SKEW_DEPTH+1 cycles, numbered f = 0..SKEW_DEPTH; then the block SHALL move to DONE.
REQ-022 FLUSH cycle f >= 1: grp_valid = 1 and grp_idx = f-1; grp_valid = 0 in every other cycle and state, and grp_idx SHALL hold its last value.
REQ-023 DONE: requant_en = 0, start_quantizing = 0, done = 1 and aborted = abort flag, for exactly one cycle; then the block SHALL move to IDLE.
REQ-024 Outputs SHALL be registered so that they take their state-decoded value in the cycle the state is entered.
REQ-025 abort SHALL be ignored in FLUSH, DONE and IDLE, except for the same-edge case in REQ-018.
REQ-026 start SHALL be ignored while busy; nothing is queued.
REQ-027 Back-to-back passes: a start in the first IDLE cycle after DONE SHALL be accepted, giving a minimum pass period of len + SKEW_DEPTH + 3 cycles.
REQ-028 Counter comparisons SHALL use the latched len; a run_len change during a pass SHALL have no effect on that pass.

Reset
REQ-029 On reset_n = 0 at a rising edge the block SHALL enter IDLE and clear requant_en, start_quantizing, grp_valid, grp_idx, done, aborted, cnt, len and the abort flag.
REQ-030 Reset mid-pass (RUN or FLUSH): on the next cycle requant_en SHALL be 0, which forces all datapath lane resets high; no done pulse SHALL follow.
REQ-031 ready SHALL be 1 in the first cycle after reset_n returns high.

Verification
REQ-032 start with run_len = 8 -> start_quantizing high for 8 cycles; requant_en high for 8 + 33 = 41 cycles; done at cycle 42 after acceptance with aborted = 0.
REQ-033 run_len = 0 -> RUN lasts 1 cycle; 32 grp_valid pulses with grp_idx 0..31 in order.
REQ-034 abort on the 3rd RUN cycle of a run_len = 20 pass -> start_quantizing high for 3 cycles; full 33-cycle FLUSH; done with aborted = 1.
REQ-035 start && abort together in IDLE -> ready stays 1 and requant_en stays 0.
REQ-036 reset_n low at FLUSH f = 10 -> next cycle all outputs 0 and ready = 1; no done pulse; a new start is accepted normally.
REQ-037 start held high continuously with run_len = 4 -> passes accepted every 4 + 35 = 39 cycles; starts while busy have no effect.

Source files
------------

// File: rtl/hwgq_seq.sv
// hwgq_seq: pass sequencer for the HWGQ quantization datapath.
//
// A pass runs IDLE -> RUN (len cycles) -> FLUSH (SKEW_DEPTH+1 cycles) -> DONE
// (1 cycle) -> IDLE. During RUN the datapath chain head is driven and the
// staggered reset chain shifts; during FLUSH the chain drains and each lane
// group is announced on grp_valid/grp_idx as it re-enters reset.
//
// Ports:
//   clk              sole clock, rising edge
//   reset_n          synchronous active-low reset
//   start            pass request, accepted when start && ready
//   run_len          RUN length in cycles (0 treated as 1), sampled on accept
//   abort            truncates RUN; also cancels a start on the same IDLE edge
//   ready            state is IDLE
//   busy             state is RUN, FLUSH or DONE
//   requant_en       registered reset-chain shift enable (RUN, FLUSH)
//   start_quantizing registered chain head drive (RUN)
//   grp_valid        registered, lane group grp_idx has settled
//   grp_idx          registered chain tap index, holds when grp_valid = 0
//   done             registered one-cycle completion pulse
//   aborted          registered, qualified by done: pass was truncated
module hwgq_seq #(
  parameter int SKEW_DEPTH = 32,
  parameter int RUN_W      = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [RUN_W-1:0] run_len,
  input  logic             abort,
  output logic             ready,
  output logic             busy,
  output logic             requant_en,
  output logic             start_quantizing,
  output logic             grp_valid,
  output logic [4:0]       grp_idx,
  output logic             done,
  output logic             aborted
);

  localparam int CNT_W = (RUN_W > 6) ? RUN_W : 6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_len, w_len_nxt;
  logic             r_abt, w_abt_nxt;

  logic             r_requant_en, r_start_q, r_grp_valid, r_done, r_aborted;
  logic [4:0]       r_grp_idx;
  logic             w_grp_valid_nxt;
  logic [4:0]       w_grp_idx_nxt;

  // Next-state and counter/len/abort-flag updates.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_len_nxt   = r_len;
    w_abt_nxt   = r_abt;
    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_len_nxt   = (run_len == '0) ? CNT_W'(1) : CNT_W'(run_len);
          w_cnt_nxt   = '0;
          w_abt_nxt   = 1'b0;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          w_abt_nxt   = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_FLUSH;
        end else if (r_cnt == r_len - CNT_W'(1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_FLUSH;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_FLUSH: begin
        // r_cnt is the flush cycle number f.
        if (r_cnt == CNT_W'(SKEW_DEPTH)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Group strobe for flush cycles f >= 1. The tap index is kept as its own
  // 5-bit register (0 on the first strobe, +1 on each following one) rather
  // than sliced from the counter, so it equals f-1 and holds between passes.
  always_comb begin
    w_grp_valid_nxt = (w_state_nxt == S_FLUSH) && (w_cnt_nxt != '0);
    w_grp_idx_nxt   = r_grp_idx;
    if (w_grp_valid_nxt) begin
      w_grp_idx_nxt = r_grp_valid ? (r_grp_idx + 5'd1) : 5'd0;
    end
  end

  // Outputs are registered from the next-state decode so they take their
  // state value in the very cycle that state is entered.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_len        <= '0;
      r_abt        <= 1'b0;
      r_requant_en <= 1'b0;
      r_start_q    <= 1'b0;
      r_grp_valid  <= 1'b0;
      r_grp_idx    <= '0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_len        <= w_len_nxt;
      r_abt        <= w_abt_nxt;
      r_requant_en <= (w_state_nxt == S_RUN) || (w_state_nxt == S_FLUSH);
      r_start_q    <= (w_state_nxt == S_RUN);
      r_grp_valid  <= w_grp_valid_nxt;
      r_grp_idx    <= w_grp_idx_nxt;
      r_done       <= (w_state_nxt == S_DONE);
      r_aborted    <= (w_state_nxt == S_DONE) && w_abt_nxt;
    end
  end

  assign ready            = (r_state == S_IDLE);
  assign busy             = (r_state != S_IDLE);
  assign requant_en       = r_requant_en;
  assign start_quantizing = r_start_q;
  assign grp_valid        = r_grp_valid;
  assign grp_idx          = r_grp_idx;
  assign done             = r_done;
  assign aborted          = r_aborted;

endmodule

// File: tb/tb_hwgq_seq.sv
// Scoreboard bench for hwgq_seq: the stimulus process pushes the expected
// grp_valid/done events (with the cycle they must appear in) into a queue;
// a monitor process pops and compares whenever the DUT strobes an output.
module tb_hwgq_seq;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [5:0] run_len;
  logic       abort;
  logic       ready, busy, requant_en, start_quantizing;
  logic       grp_valid, done, aborted;
  logic [4:0] grp_idx;

  hwgq_seq #(.SKEW_DEPTH(32), .RUN_W(6)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .run_len          (run_len),
    .abort            (abort),
    .ready            (ready),
    .busy             (busy),
    .requant_en       (requant_en),
    .start_quantizing (start_quantizing),
    .grp_valid        (grp_valid),
    .grp_idx          (grp_idx),
    .done             (done),
    .aborted          (aborted)
  );

  typedef struct {
    bit is_done;
    int cyc;
    int val;
  } ev_t;

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;
  int  sq_cnt   = 0;
  int  re_cnt   = 0;
  bit  mon_en   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cyc %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push_ev(input bit is_done, input int c, input int v);
    ev_t e;
    e.is_done = is_done;
    e.cyc     = c;
    e.val     = v;
    exp_q.push_back(e);
  endtask

  // Monitor
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (start_quantizing) sq_cnt++;
        if (requant_en) re_cnt++;
        chk("ready_vs_busy", int'(ready ^ busy), 1);
        if (grp_valid && done) chk("grp_valid_with_done", 1, 0);
        if (grp_valid || done) begin
          if (exp_q.size() == 0) begin
            chk(done ? "unexpected_done" : "unexpected_grp_valid", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk(e.is_done ? "ev_kind_done" : "ev_kind_grp", int'(done), int'(e.is_done));
            chk(e.is_done ? "done_cycle" : "grp_cycle", cyc, e.cyc);
            if (e.is_done) chk("done_aborted", int'(aborted), e.val);
            else           chk("grp_idx", int'(grp_idx), e.val);
          end
        end
      end
    end
  end

  // One pass. abort_at / rst_at are cycle numbers after acceptance (cycle 1
  // is the first RUN cycle); 0 disables them.
  task automatic run_pass(input int rl, input int abort_at, input int rst_at);
    int len_eff, run_cyc, acc, n, f;
    bit ab, fin;
    len_eff = (rl == 0) ? 1 : rl;
    ab      = (abort_at > 0) && (abort_at <= len_eff);
    run_cyc = ab ? abort_at : len_eff;

    @(negedge clk);
    start   = 1'b1;
    abort   = 1'b0;
    run_len = 6'(rl);
    @(posedge clk);
    #1;
    acc = cyc;
    chk("accept_busy", int'(busy), 1);
    sq_cnt = 0;
    re_cnt = 0;
    for (f = 1; f <= 32; f++) begin
      if (rst_at == 0 || (run_cyc + 1 + f) <= rst_at)
        push_ev(1'b0, acc + run_cyc + f, f - 1);
    end
    if (rst_at == 0) push_ev(1'b1, acc + run_cyc + 33, int'(ab));
    run_len = ~run_len;  // must not affect the pass in flight

    fin = 0;
    for (int k = 0; k < 300 && !fin; k++) begin
      @(negedge clk);
      n = cyc - acc + 1;
      if (rst_at != 0 && n == rst_at + 1) begin
        chk("rst_requant_en", int'(requant_en), 0);
        chk("rst_start_q", int'(start_quantizing), 0);
        chk("rst_grp_valid", int'(grp_valid), 0);
        chk("rst_grp_idx", int'(grp_idx), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_aborted", int'(aborted), 0);
        chk("rst_ready", int'(ready), 1);
      end
      if (rst_at != 0 && n == rst_at + 41) fin = 1;
      if (done) begin
        fin = 1;
        chk("sq_cycles", sq_cnt, run_cyc);
        chk("re_cycles", re_cnt, run_cyc + 33);
      end
      start   = (n <= 2);
      abort   = (n == abort_at);
      reset_n = !(rst_at != 0 && n == rst_at);
    end
    if (!fin) chk("pass_timeout", 0, 1);
    start   = 1'b0;
    abort   = 1'b0;
    reset_n = 1'b1;
  endtask

  initial begin
    int acc, dones;
    reset_n = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    run_len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", int'(ready), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_requant_en", int'(requant_en), 0);
    chk("reset_start_q", int'(start_quantizing), 0);
    chk("reset_grp_valid", int'(grp_valid), 0);
    chk("reset_grp_idx", int'(grp_idx), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_aborted", int'(aborted), 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", int'(ready), 1);
    mon_en = 1;

    run_pass(8, 0, 0);    // nominal
    run_pass(0, 0, 0);    // zero length -> one RUN cycle
    run_pass(20, 3, 0);   // abort on 3rd RUN cycle
    run_pass(5, 12, 0);   // abort during FLUSH is ignored
    run_pass(1, 1, 0);    // abort on the only RUN cycle
    run_pass(63, 0, 0);   // maximum length

    // start together with abort in IDLE is dropped
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    chk("startabort_ready", int'(ready), 1);
    chk("startabort_requant", int'(requant_en), 0);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("startabort_busy", int'(busy), 0);

    run_pass(5, 0, 16);   // reset at FLUSH f = 10, no done
    run_pass(2, 0, 0);    // normal pass after the reset

    // start held high: back-to-back passes every 4 + 35 cycles
    @(negedge clk);
    start   = 1'b1;
    run_len = 6'd4;
    @(posedge clk);
    #1;
    acc    = cyc;
    sq_cnt = 0;
    re_cnt = 0;
    for (int p = 0; p < 3; p++) begin
      for (int f = 1; f <= 32; f++) push_ev(1'b0, acc + 39 * p + 4 + f, f - 1);
      push_ev(1'b1, acc + 39 * p + 37, 0);
    end
    dones = 0;
    for (int k = 0; k < 400 && dones < 3; k++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        if (dones == 3) start = 1'b0;
      end
    end
    chk("b2b_dones", dones, 3);
    chk("b2b_sq_cycles", sq_cnt, 12);
    chk("b2b_re_cycles", re_cnt, 111);
    @(negedge clk);
    chk("b2b_idle_ready", int'(ready), 1);
    @(negedge clk);
    chk("b2b_no_restart", int'(busy), 0);

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
